// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter: grants each draw source in turn for one frame compose and
// pipelines its accepted pixels into linear framebuffer writes.
module frame_write_arbiter #(
    parameter int SOURCE_COUNT     = 3,
    parameter int SOURCE_SEL_ADDRW = 4,
    parameter int COLOR_DEPTH      = 9,
    parameter int FB_WIDTH         = 640,
    parameter int FB_HEIGHT        = 480,
    parameter int WAIT_TIMEOUT     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    input  logic                        write_active,
    input  logic [COLOR_DEPTH-1:0]      write_color_data,
    input  logic                        write_transparent,
    input  logic [31:0]                 write_x_addr,
    input  logic [31:0]                 write_y_addr,
    output logic                        fb_we,
    output logic [18:0]                 fb_addr,
    output logic [COLOR_DEPTH-1:0]      fb_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        timeout_err,
    output logic                        overrun_err
);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_ACTIVE, STREAM, NEXT, DONE} state_t;
    localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SEL = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);

    state_t                      state_q, state_d;
    logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic                        awaited_q, awaited_d, busy_q, busy_d, done_q, done_d;
    logic                        timeout_err_q, timeout_err_d, overrun_err_q, overrun_err_d;
    logic                        fb_we_q, fb_we_d;
    logic [18:0]                 fb_addr_q, fb_addr_d;
    logic [COLOR_DEPTH-1:0]      fb_data_q, fb_data_d;
    logic                        act, take, wr;

    // Anything other than a clean 1 on write_active means the bus is not ours to read.
    assign act  = (write_active === 1'b1);
    // A source's pixel is valid from its very first active cycle, including the one that ends WAIT_ACTIVE.
    assign take = act && (state_q == WAIT_ACTIVE || state_q == STREAM);
    assign wr   = take && !write_transparent && write_x_addr < 32'(FB_WIDTH) && write_y_addr < 32'(FB_HEIGHT);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q || (frame_start && state_q != IDLE);
        case (state_q)
            IDLE: if (frame_start) begin
                state_d = GRANT;
                sel_d   = '0;
            end
            GRANT: begin
                state_d = WAIT_ACTIVE;
                cnt_d   = '0;
            end
            // cnt counts cycles since the grant pulse minus one, so the error shows WAIT_TIMEOUT cycles after it.
            WAIT_ACTIVE: if (act) state_d = STREAM;
            else if (cnt_q == 32'(WAIT_TIMEOUT - 2)) begin
                state_d       = NEXT;
                timeout_err_d = 1'b1;
            end else cnt_d = cnt_q + 32'd1;
            STREAM: if (!act) state_d = NEXT;
            NEXT: if (sel_q == LAST_SEL) state_d = DONE;
            else begin
                state_d = GRANT;
                sel_d   = sel_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                sel_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        awaited_d = (state_d == GRANT);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        fb_we_d   = wr;
        fb_addr_d = wr ? 19'(write_y_addr * 32'(FB_WIDTH) + write_x_addr) : fb_addr_q;
        fb_data_d = wr ? write_color_data : fb_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            awaited_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            awaited_q     <= awaited_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
        end
    end

    assign write_source_sel = sel_q;
    assign write_awaited    = awaited_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;
    assign timeout_err      = timeout_err_q;
    assign overrun_err      = overrun_err_q;
    assign fb_we            = fb_we_q;
    assign fb_addr          = fb_addr_q;
    assign fb_data          = fb_data_q;
endmodule

// File: doc/frame_write_arbiter.md
FRAME_WRITE_ARBITER -- requirements
Module: frame_write_arbiter

Interface
REQ-001 SHALL have parameter SOURCE_COUNT, default 3, number of draw sources sequenced per frame (IDs 0..SOURCE_COUNT-1, ID 0 drawn first).
REQ-002 SHALL have parameter SOURCE_SEL_ADDRW, default 4, width of write_source_sel.
REQ-003 SHALL have parameter COLOR_DEPTH, default 9, pixel color width.
REQ-004 SHALL have parameters FB_WIDTH, default 640, and FB_HEIGHT, default 480, the framebuffer dimensions in pixels.
REQ-005 SHALL have parameter WAIT_TIMEOUT, default 16, the maximum number of cycles allowed from the write_awaited pulse to write_active.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse requesting a full frame compose.
REQ-009 SHALL have port write_source_sel, output, SOURCE_SEL_ADDRW bits: currently granted source ID.
REQ-010 SHALL have port write_awaited, output, 1 bit: one-cycle grant pulse to the selected source.
REQ-011 SHALL have port write_active, input, 1 bit: the selected source is streaming pixels.
REQ-012 SHALL have port write_color_data, input, COLOR_DEPTH bits: pixel color.
REQ-013 SHALL have port write_transparent, input, 1 bit: pixel shall not be written.
REQ-014 SHALL have ports write_x_addr and write_y_addr, input, 32 bits each: pixel coordinates.
REQ-015 SHALL have port fb_we, output, 1 bit: framebuffer write enable.
REQ-016 SHALL have port fb_addr, output, 19 bits: linear framebuffer address.
REQ-017 SHALL have port fb_data, output, COLOR_DEPTH bits: framebuffer write data.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 SHALL have port frame_done, output, 1 bit: one-cycle pulse at compose completion.
REQ-020 SHALL have port timeout_err, output, 1 bit: sticky flag, set when a source times out.
REQ-021 SHALL have port overrun_err, output, 1 bit: sticky flag, set when frame_start arrives while busy.

Function
REQ-022 SHALL implement states IDLE, GRANT, WAIT_ACTIVE, STREAM, NEXT and DONE.
REQ-023 IDLE: SHALL go to GRANT on frame_start=1, with write_source_sel set to 0.
REQ-024 GRANT (1 cycle): SHALL assert write_awaited=1 and then go to WAIT_ACTIVE with the timeout counter cleared.
REQ-025 WAIT_ACTIVE: on write_active===1, SHALL go to STREAM; if the counter reaches WAIT_TIMEOUT first, SHALL set timeout_err and go to NEXT.
REQ-026 STREAM: each cycle write_active===1, SHALL sample the pixel; the first cycle write_active is not 1 SHALL go to NEXT.
REQ-027 Bus inputs SHALL be treated as don't-care (Z/X tolerated) whenever write_active is not exactly 1.
REQ-028 NEXT: if write_source_sel==SOURCE_COUNT-1, SHALL go to DONE; otherwise SHALL increment write_source_sel and go to GRANT.
REQ-029 DONE (1 cycle): SHALL pulse frame_done=1, set write_source_sel to 0, and go to IDLE.
REQ-030 write_source_sel SHALL be held stable from GRANT through NEXT, since sources gate their bus drivers on it.
REQ-031 Write pipeline: a pixel sampled at cycle N SHALL produce fb_we=1 at cycle N+1, with registered fb_addr=y*FB_WIDTH+x and fb_data=color.
REQ-032 fb_addr arithmetic SHALL use the 19 LSBs of a product at least 32 bits wide; max address 307199.
REQ-033 A sampled pixel with write_transparent=1 SHALL produce fb_we=0.
REQ-034 A sampled pixel with x>=FB_WIDTH or y>=FB_HEIGHT SHALL produce fb_we=0.
REQ-035 fb_we SHALL be 0 in every cycle not covered by REQ-031.
REQ-036 fb_addr and fb_data SHALL hold their last values when fb_we=0.
REQ-037 The final pixel of a stream SHALL still be written (pipeline drains) even if the state has already advanced to NEXT.
REQ-038 frame_start while busy=1 SHALL be ignored and SHALL set overrun_err.
REQ-039 frame_start coincident with DONE SHALL be ignored and SHALL set overrun_err.
REQ-040 Throughput SHALL be one pixel per cycle with no stalls.

Reset
REQ-041 reset=1 at a clock edge SHALL force IDLE.
REQ-042 reset SHALL set write_source_sel=0, write_awaited=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, timeout_err=0 and overrun_err=0 on that edge.
REQ-043 reset mid-STREAM SHALL suppress any in-flight pipeline write.
REQ-044 After reset deasserts, the block SHALL remain in IDLE until frame_start.

Verification
REQ-045 Single source (SOURCE_COUNT=1) streaming a 640x480 raster, opaque, color 9'h092 -> 307200 fb_we pulses, last fb_addr=307199, one frame_done pulse, busy low afterwards.
REQ-046 Three sources, source 1 marks pixel (5,2) transparent -> fb_we=0 for addr 1285 during source 1 only; grant order 0,1,2 observed on write_source_sel.
REQ-047 Source 2 never raises write_active -> timeout_err=1 exactly WAIT_TIMEOUT cycles after its write_awaited, followed by frame_done.
REQ-048 Source emits x=640,y=0 and x=0,y=480 -> no fb_we for either; adjacent in-range pixels written.
REQ-049 frame_start pulsed mid-STREAM -> overrun_err=1, no second frame composed.
REQ-050 reset asserted mid-STREAM for 1 cycle -> next cycle fb_we=0, busy=0, all outputs at reset values.
